bit_serial_adder: RTL

Multi-cycle adder controller that time-shares a single `Full_Adder` instance to add two WIDTH-bit operands one bit per clock, LSB first. Sequences operand shifting, carry feedback and result assembly behind a start/done handshake. Used wherever area matters more than latency and a full ripple adder is not wanted.

---
 rtl/bit_serial_adder_pkg.sv | 22 ++
 rtl/Full_Adder.sv | 19 +
 rtl/bit_serial_adder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Purpose: shared FSM encodings and sizing helper for bit_serial_adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   ST_IDLE / ST_RUN / ST_DONE - controller state encodings
//   state_t                    - state register type
//   cnt_width()                - bit-counter width for a given operand width
package bit_serial_adder_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter only needs to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/Full_Adder.sv
// Purpose: single-bit full adder, the only arithmetic element of the serial adder.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   a, b, cin - addend bits and carry in
//   sum, cout - sum bit and carry out
module Full_Adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// Purpose: adds two WIDTH-bit operands one bit per clock, LSB first, through one shared Full_Adder.
// Latency: WIDTH cycles from the start-accept edge to done; one operation per WIDTH+1 cycles.
// Backpressure: start is only honoured in IDLE or on the DONE exit edge; otherwise it is dropped, never queued.
//
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   start, a, b, cin  - request and operands, captured when the request is accepted
//   sub               - subtract select (only with BIT_SERIAL_ADDER_SUB_EN defined)
//   busy              - high while an operation is in RUN or DONE
//   done              - one-cycle pulse when sum/cout carry a fresh result
//   sum, cout         - result of the last completed operation, held until the next one completes
//
// Build option: define BIT_SERIAL_ADDER_SUB_EN to add the sub port (a - b, cout=1 means no borrow).
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef BIT_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-2:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  // Subtraction is a + ~b + 1, so it reuses the same adder path with
  // B inverted at capture time and the carry preset to 1.
`ifdef BIT_SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  Full_Adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Partial result with this cycle's bit shifted in at the MSB. After the
  // WIDTH-th bit it is the complete, correctly aligned sum.
  assign sum_next = {fa_sum, sum_sr_q};

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        sum_sr_d = sum_next[WIDTH-1:1];
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = sum_next;
          cout_d  = fa_cout;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // The DONE exit edge doubles as an acceptance edge so back-to-back
        // requests run every WIDTH+1 cycles. The result is already committed
        // to sum_q/cout_q, so new operands cannot disturb it.
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up with
    // the state register rather than lagging it by a cycle.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
